shift_writeback: RTL and testbench

Writeback stage directly downstream of the 8-bit shift/rotate unit. It captures each shifter result and carry, together with the destination register and flag-update request, in a 2-entry buffer. It drains entries to the register-file write port under a ready handshake and maintains the architectural carry (C) and zero (Z) flags in writeback order. The buffer decouples the combinational shifter from register-file stalls.

---
 rtl/shift_writeback_if.sv | 38 +++
 rtl/shift_writeback.sv | 80 ++++++++
 tb/tb_shift_writeback.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_writeback_if.sv
// shift_writeback_if: bundles the shifter-side push port, the register-file
// write port and the architectural flag outputs of the writeback stage.
//   inValid/inReady           push handshake from the shift/rotate unit
//   shiftResult/shiftCarry    shifter result and raw carry
//   operation/shiftCount      op executed (00 SHL, 01 SHR, 10 ROL, 11 ROR) and count
//   destReg/updateFlags       destination register and C/Z update request
//   flush                     synchronous discard of buffered entries
//   rfReady/wbEn/wbAddr/wbData register-file write port
//   flagC/flagZ               architectural carry and zero flags
interface shift_writeback_if;
    logic       inValid;
    logic       inReady;
    logic [7:0] shiftResult;
    logic       shiftCarry;
    logic [1:0] operation;
    logic [2:0] shiftCount;
    logic [2:0] destReg;
    logic       updateFlags;
    logic       flush;
    logic       rfReady;
    logic       wbEn;
    logic [2:0] wbAddr;
    logic [7:0] wbData;
    logic       flagC;
    logic       flagZ;

    modport master (
        output inValid, shiftResult, shiftCarry, operation, shiftCount,
               destReg, updateFlags, flush, rfReady,
        input  inReady, wbEn, wbAddr, wbData, flagC, flagZ
    );

    modport slave (
        input  inValid, shiftResult, shiftCarry, operation, shiftCount,
               destReg, updateFlags, flush, rfReady,
        output inReady, wbEn, wbAddr, wbData, flagC, flagZ
    );
endinterface

// File: rtl/shift_writeback.sv
// shift_writeback: 2-entry writeback buffer behind the 8-bit shift/rotate unit.
// Captures result, resolved carry, destination and flag request at push, drains
// in order to the register-file write port and updates C/Z at pop.
//   clk   rising-edge clock
//   rstN  asynchronous active-low reset
//   bus   shift_writeback_if.slave (push port, write port, flags)
module shift_writeback #(
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rstN,
    shift_writeback_if.slave bus
);
    logic [7:0] data_q   [DEPTH];
    logic       carry_q  [DEPTH];
    logic       keep_c_q [DEPTH];
    logic       upd_q    [DEPTH];
    logic [2:0] dest_q   [DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       flag_c;
    logic       flag_z;
    logic       push;
    logic       pop;
    logic       not_empty;
    logic       new_carry;

    assign not_empty = (count != 2'd0);
    assign bus.inReady = (count < 2'(DEPTH)) && !bus.flush;
    assign bus.wbEn    = not_empty && bus.rfReady && !bus.flush;
    assign bus.wbAddr  = not_empty ? dest_q[rd_ptr] : 3'd0;
    assign bus.wbData  = not_empty ? data_q[rd_ptr] : 8'd0;
    assign bus.flagC   = flag_c;
    assign bus.flagZ   = flag_z;
    assign push = bus.inValid && bus.inReady;
    assign pop  = bus.wbEn;
    // Rotates report the bit that wrapped around; shifts use the shifter's carry.
    assign new_carry = bus.operation[1] ? (bus.operation[0] ? bus.shiftResult[7] : bus.shiftResult[0])
                                        : bus.shiftCarry;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]   <= 8'd0;
                carry_q[i]  <= 1'b0;
                keep_c_q[i] <= 1'b0;
                upd_q[i]    <= 1'b0;
                dest_q[i]   <= 3'd0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr]   <= bus.shiftResult;
                carry_q[wr_ptr]  <= new_carry;
                keep_c_q[wr_ptr] <= (bus.shiftCount == 3'd0);
                upd_q[wr_ptr]    <= bus.updateFlags;
                dest_q[wr_ptr]   <= bus.destReg;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (upd_q[rd_ptr]) begin
                    flag_z <= (data_q[rd_ptr] == 8'd0);
                    if (!keep_c_q[rd_ptr])
                        flag_c <= carry_q[rd_ptr];
                end
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_shift_writeback.sv
// tb_shift_writeback: directed self-checking bench for shift_writeback.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_shift_writeback;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int checks = 0;
    int errors = 0;

    shift_writeback_if bus();

    shift_writeback #(.DEPTH(2)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] res, input logic c,
                         input logic [1:0] op, input logic [2:0] cnt,
                         input logic [2:0] d, input logic u);
        bus.inValid     = v;
        bus.shiftResult = res;
        bus.shiftCarry  = c;
        bus.operation   = op;
        bus.shiftCount  = cnt;
        bus.destReg     = d;
        bus.updateFlags = u;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b en=%b a=%h d=%h c=%b z=%b want rdy=1 en=0 a=0 d=00 c=0 z=0",
                     bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ);
        end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn} !== 2'b10) begin
            errors++;
            $display("FAIL idle got rdy=%b en=%b want rdy=1 en=0", bus.inReady, bus.wbEn);
        end
    endtask

    task automatic test_single_shl;
        @(negedge clk);
        bus.rfReady = 1'b1;
        drive(1'b1, 8'h50, 1'b1, 2'b00, 3'd3, 3'd5, 1'b1);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn} !== 2'b10) begin
            errors++;
            $display("FAIL shl_push got rdy=%b en=%b want rdy=1 en=0", bus.inReady, bus.wbEn);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b1, 3'd5, 8'h50}) begin
            errors++;
            $display("FAIL shl_write got en=%b a=%h d=%h want en=1 a=5 d=50", bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.wbEn, bus.flagC, bus.flagZ} !== 3'b010) begin
            errors++;
            $display("FAIL shl_flags got en=%b c=%b z=%b want en=0 c=1 z=0", bus.wbEn, bus.flagC, bus.flagZ);
        end
    endtask

    task automatic test_carry_rules;
        // ROR takes C from result[7] (shiftCarry deliberately 0).
        @(negedge clk);
        drive(1'b1, 8'h80, 1'b0, 2'b11, 3'd1, 3'd1, 1'b1);
        @(negedge clk);
        // SHR with count 0 keeps C; pushed while the ROR entry pops.
        drive(1'b1, 8'h00, 1'b0, 2'b01, 3'd0, 3'd2, 1'b1);
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b1, 3'd1, 8'h80}) begin
            errors++;
            $display("FAIL ror_write got en=%b a=%h d=%h want en=1 a=1 d=80", bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.flagC, bus.flagZ, bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b1, 1'b0, 1'b1, 3'd2, 8'h00}) begin
            errors++;
            $display("FAIL ror_flags got c=%b z=%b en=%b a=%h d=%h want c=1 z=0 en=1 a=2 d=00",
                     bus.flagC, bus.flagZ, bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.flagC, bus.flagZ, bus.wbEn} !== 3'b110) begin
            errors++;
            $display("FAIL shr_keepc got c=%b z=%b en=%b want c=1 z=1 en=0", bus.flagC, bus.flagZ, bus.wbEn);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.rfReady = 1'b0;
        // A: ROL, C from result[0]=0 although shiftCarry=1.
        drive(1'b1, 8'h02, 1'b1, 2'b10, 3'd1, 3'd1, 1'b1);
        #1;
        checks++;
        if (bus.inReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy_a got %b want 1", bus.inReady);
        end
        @(negedge clk);
        // B: no flag update.
        drive(1'b1, 8'h00, 1'b1, 2'b00, 3'd4, 3'd2, 1'b0);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_rdy_b got rdy=%b en=%b want rdy=1 en=0", bus.inReady, bus.wbEn);
        end
        @(negedge clk);
        // C: ROL, C from result[0]=1.
        drive(1'b1, 8'h81, 1'b0, 2'b10, 3'd1, 3'd3, 1'b1);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b0, 1'b0, 3'd1, 8'h02}) begin
            errors++;
            $display("FAIL b2b_full got rdy=%b en=%b a=%h d=%h want rdy=0 en=0 a=1 d=02",
                     bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        bus.rfReady = 1'b1;
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b0, 1'b1, 3'd1, 8'h02}) begin
            errors++;
            $display("FAIL b2b_pop_a got rdy=%b en=%b a=%h d=%h want rdy=0 en=1 a=1 d=02",
                     bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ} !== {1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_pop_b got rdy=%b en=%b a=%h d=%h c=%b z=%b want rdy=1 en=1 a=2 d=00 c=0 z=0",
                     bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ} !== {1'b1, 3'd3, 8'h81, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_pop_c got en=%b a=%h d=%h c=%b z=%b want en=1 a=3 d=81 c=0 z=0",
                     bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.wbEn, bus.flagC, bus.flagZ} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_drained got en=%b c=%b z=%b want en=0 c=1 z=0", bus.wbEn, bus.flagC, bus.flagZ);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        bus.rfReady = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 2'b00, 3'd1, 3'd4, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h22, 1'b0, 2'b00, 3'd1, 3'd6, 1'b1);
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.rfReady = 1'b1;
        drive(1'b1, 8'h33, 1'b0, 2'b00, 3'd1, 3'd7, 1'b1);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn} !== 2'b00) begin
            errors++;
            $display("FAIL flush_cycle got rdy=%b en=%b want rdy=0 en=0", bus.inReady, bus.wbEn);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush_empty got rdy=%b en=%b a=%h d=%h c=%b z=%b want rdy=1 en=0 a=0 d=00 c=1 z=0",
                     bus.inReady, bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ);
        end
        drive(1'b1, 8'h44, 1'b0, 2'b00, 3'd2, 3'd2, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b1, 3'd2, 8'h44}) begin
            errors++;
            $display("FAIL flush_resume got en=%b a=%h d=%h want en=1 a=2 d=44", bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus.rfReady = 1'b0;
        drive(1'b1, 8'h55, 1'b1, 2'b00, 3'd1, 3'd1, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h66, 1'b1, 2'b00, 3'd1, 3'd2, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        bus.rfReady = 1'b1;
        #1;
        checks++;
        if ({bus.wbEn, bus.wbData, bus.flagC} !== {1'b1, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL arst_pre got en=%b d=%h c=%b want en=1 d=55 c=1", bus.wbEn, bus.wbData, bus.flagC);
        end
        #1;
        rstN = 1'b0;
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ, bus.inReady} !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_now got en=%b a=%h d=%h c=%b z=%b rdy=%b want en=0 a=0 d=00 c=0 z=0 rdy=1",
                     bus.wbEn, bus.wbAddr, bus.wbData, bus.flagC, bus.flagZ, bus.inReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checks++;
        if ({bus.wbEn, bus.inReady} !== 2'b01) begin
            errors++;
            $display("FAIL arst_empty got en=%b rdy=%b want en=0 rdy=1", bus.wbEn, bus.inReady);
        end
        drive(1'b1, 8'h00, 1'b1, 2'b01, 3'd2, 3'd3, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        #1;
        checks++;
        if ({bus.wbEn, bus.wbAddr, bus.wbData} !== {1'b1, 3'd3, 8'h00}) begin
            errors++;
            $display("FAIL arst_resume got en=%b a=%h d=%h want en=1 a=3 d=00", bus.wbEn, bus.wbAddr, bus.wbData);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.wbEn, bus.flagC, bus.flagZ} !== 3'b011) begin
            errors++;
            $display("FAIL arst_flags got en=%b c=%b z=%b want en=0 c=1 z=1", bus.wbEn, bus.flagC, bus.flagZ);
        end
    endtask

    initial begin
        bus.flush   = 1'b0;
        bus.rfReady = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        test_reset();
        test_single_shl();
        test_carry_rules();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
